// File: rtl/mesh_timestep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mesh_timestep_scheduler
// Brief    : Global SNN timestep sequencer; broadcasts step-start, gathers
//            node-done flags, waits for NoC drain, traps hung nodes.
// Revision : 1.0 - initial release
// ============================================================================
module mesh_timestep_scheduler #(
    parameter int NUM_NODES    = 4,
    parameter int TS_WIDTH     = 16,
    parameter int TO_WIDTH     = 16,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [TS_WIDTH-1:0]  cfg_num_steps,
    input  logic [TO_WIDTH-1:0]  cfg_timeout,
    input  logic [NUM_NODES-1:0] node_done,
    input  logic                 noc_idle,
    output logic                 step_start,
    output logic [TS_WIDTH-1:0]  timestep,
    output logic                 busy,
    output logic                 run_done,
    output logic                 timeout_err,
    output logic [NUM_NODES-1:0] pending_mask
);

    localparam int                   c_drain_w      = $clog2(DRAIN_CYCLES + 1);
    localparam logic [c_drain_w-1:0] c_drain_target = c_drain_w'(DRAIN_CYCLES);
    localparam logic [NUM_NODES-1:0] c_all_ones     = '1;

    typedef enum logic [2:0] {
        c_idle    = 3'd0,
        c_start   = 3'd1,
        c_compute = 3'd2,
        c_drain   = 3'd3,
        c_advance = 3'd4,
        c_done    = 3'd5,
        c_error   = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [TS_WIDTH-1:0]    r_num_steps;
    logic [TO_WIDTH-1:0]    r_timeout;
    logic [TS_WIDTH-1:0]    r_timestep;
    logic [NUM_NODES-1:0]   r_latch;
    logic [NUM_NODES-1:0]   r_pending;
    logic [TO_WIDTH-1:0]    r_wd;
    logic [c_drain_w-1:0]   r_drain;

    logic [NUM_NODES-1:0]   w_done_acc;
    logic                   w_all_done;
    logic [TO_WIDTH-1:0]    w_wd_inc;
    logic                   w_wd_expire;
    logic [c_drain_w-1:0]   w_drain_inc;
    logic                   w_drained;
    logic                   w_last_step;
    logic                   w_abort;
    logic                   w_accept;

    assign w_done_acc  = r_latch | node_done;
    assign w_all_done  = (w_done_acc == c_all_ones);
    assign w_wd_inc    = r_wd + TO_WIDTH'(1);
    assign w_wd_expire = (r_timeout != '0) && (w_wd_inc == r_timeout);
    assign w_drain_inc = r_drain + c_drain_w'(1);
    assign w_drained   = noc_idle && (w_drain_inc == c_drain_target);
    assign w_last_step = (r_timestep == (r_num_steps - TS_WIDTH'(1)));
    assign w_abort     = abort && (r_state != c_idle);
    assign w_accept    = (r_state == c_idle) && start && (cfg_num_steps != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // All-done is tested before the watchdog so a same-cycle tie goes to DRAIN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_state_nxt = (cfg_num_steps != '0) ? c_start : c_done;
                end
            end
            c_start:   w_state_nxt = c_compute;
            c_compute: begin
                if (w_all_done) begin
                    w_state_nxt = c_drain;
                end else if (w_wd_expire) begin
                    w_state_nxt = c_error;
                end
            end
            c_drain: begin
                if (w_drained) begin
                    w_state_nxt = c_advance;
                end
            end
            c_advance: w_state_nxt = w_last_step ? c_done : c_start;
            c_done:    w_state_nxt = c_idle;
            c_error:   w_state_nxt = c_error;
            default:   w_state_nxt = c_idle;
        endcase
        if (w_abort) begin
            w_state_nxt = c_idle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_num_steps <= '0;
            r_timeout   <= '0;
            r_timestep  <= '0;
            r_latch     <= '0;
            r_pending   <= '0;
            r_wd        <= '0;
            r_drain     <= '0;
        end else if (w_abort) begin
            r_timestep  <= '0;
            r_latch     <= '0;
            r_pending   <= '0;
            r_wd        <= '0;
            r_drain     <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_num_steps <= cfg_num_steps;
                        r_timeout   <= cfg_timeout;
                        r_timestep  <= '0;
                    end
                end
                // node_done is stale here, so the latch restarts from zero.
                c_start: begin
                    r_latch   <= '0;
                    r_pending <= c_all_ones;
                    r_wd      <= '0;
                    r_drain   <= '0;
                end
                c_compute: begin
                    r_latch   <= w_done_acc;
                    r_pending <= ~w_done_acc;
                    if (!w_all_done) begin
                        r_wd <= w_wd_inc;
                    end
                end
                c_drain: begin
                    r_drain <= noc_idle ? w_drain_inc : '0;
                end
                c_advance: begin
                    r_drain <= '0;
                    if (!w_last_step) begin
                        r_timestep <= r_timestep + TS_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign step_start   = (r_state == c_start);
    assign busy         = (r_state != c_idle);
    assign run_done     = (r_state == c_done);
    assign timeout_err  = (r_state == c_error);
    assign timestep     = r_timestep;
    assign pending_mask = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_mesh_timestep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mesh_timestep_scheduler
// Brief    : Self-checking bench: directed scenarios plus random traffic
//            against a phase-level reference model of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mesh_timestep_scheduler;

    localparam int NN  = 4;
    localparam int TSW = 16;
    localparam int TOW = 16;
    localparam int DC  = 8;

    localparam int PH_IDLE    = 0;
    localparam int PH_START   = 1;
    localparam int PH_COMPUTE = 2;
    localparam int PH_DRAIN   = 3;
    localparam int PH_ADVANCE = 4;
    localparam int PH_DONE    = 5;
    localparam int PH_ERROR   = 6;

    logic           clk = 1'b1;
    logic           rst, start, abort, noc_idle;
    logic [TSW-1:0] cfg_num_steps;
    logic [TOW-1:0] cfg_timeout;
    logic [NN-1:0]  node_done;
    logic           step_start, busy, run_done, timeout_err;
    logic [TSW-1:0] timestep;
    logic [NN-1:0]  pending_mask;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int ph = PH_IDLE;
    int m_n = 0, m_to = 0, m_ts = 0, m_wd = 0, m_run = 0;
    int m_got = 0, m_pend = 0;

    always #5 clk = ~clk;

    mesh_timestep_scheduler #(
        .NUM_NODES   (NN),
        .TS_WIDTH    (TSW),
        .TO_WIDTH    (TOW),
        .DRAIN_CYCLES(DC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_num_steps(cfg_num_steps),
        .cfg_timeout  (cfg_timeout),
        .node_done    (node_done),
        .noc_idle     (noc_idle),
        .step_start   (step_start),
        .timestep     (timestep),
        .busy         (busy),
        .run_done     (run_done),
        .timeout_err  (timeout_err),
        .pending_mask (pending_mask)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advances the reference by one clock edge using the inputs of this cycle.
    task automatic model_step();
        int full;
        full = (1 << NN) - 1;
        if (!rst) begin
            ph = PH_IDLE; m_ts = 0; m_pend = 0;
        end else if (abort && ph != PH_IDLE) begin
            ph = PH_IDLE; m_ts = 0; m_pend = 0;
        end else begin
            case (ph)
                PH_IDLE: if (start) begin
                    if (cfg_num_steps != 0) begin
                        m_n = int'(cfg_num_steps); m_to = int'(cfg_timeout);
                        m_ts = 0; ph = PH_START;
                    end else begin
                        ph = PH_DONE;
                    end
                end
                PH_START: begin
                    m_got = 0; m_pend = full; m_wd = 0; m_run = 0; ph = PH_COMPUTE;
                end
                PH_COMPUTE: begin
                    m_got = m_got | int'(node_done);
                    m_pend = full & ~m_got;
                    if (m_got == full) ph = PH_DRAIN;
                    else begin
                        m_wd++;
                        if (m_to != 0 && m_wd == m_to) ph = PH_ERROR;
                    end
                end
                PH_DRAIN: begin
                    m_run = noc_idle ? m_run + 1 : 0;
                    if (m_run == DC) ph = PH_ADVANCE;
                end
                PH_ADVANCE: begin
                    if (m_ts == m_n - 1) ph = PH_DONE;
                    else begin m_ts++; ph = PH_START; end
                end
                PH_DONE: ph = PH_IDLE;
                default: ;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("step_start",   32'(step_start),   32'(ph == PH_START));
            cmp("busy",         32'(busy),         32'(ph != PH_IDLE));
            cmp("run_done",     32'(run_done),     32'(ph == PH_DONE));
            cmp("timeout_err",  32'(timeout_err),  32'(ph == PH_ERROR));
            cmp("timestep",     32'(timestep),     32'(m_ts));
            cmp("pending_mask", 32'(pending_mask), 32'(m_pend));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 1'b1; start = 1'b0; abort = 1'b0; node_done = '0; noc_idle = 1'b1;
        cfg_num_steps = '0; cfg_timeout = '0;
    endtask

    task automatic check_all_zero(input string name);
        cmp({name, "_busy"}, 32'(busy), 0);
        cmp({name, "_ss"},   32'(step_start), 0);
        cmp({name, "_rd"},   32'(run_done), 0);
        cmp({name, "_te"},   32'(timeout_err), 0);
        cmp({name, "_ts"},   32'(timestep), 0);
        cmp({name, "_pm"},   32'(pending_mask), 0);
    endtask

    initial begin
        int n_ss, rd_age;
        int ss_age[3];
        int ss_ts[3];

        // Reset with random inputs
        quiet();
        for (int i = 0; i < 3; i++) begin
            rst = 1'b0; start = 1'($urandom); abort = 1'($urandom);
            cfg_num_steps = TSW'($urandom); cfg_timeout = TOW'($urandom);
            node_done = NN'($urandom); noc_idle = 1'($urandom);
            tick();
            chk_en = 1'b1;
            check_all_zero("reset");
        end
        quiet();
        tick(); tick();
        check_all_zero("post_reset");

        // Normal run: three back-to-back minimum-length steps
        cfg_num_steps = 3; node_done = '1; start = 1'b1;
        tick();
        start = 1'b0;
        n_ss = 0; rd_age = -1;
        for (int age = 0; age < 40; age++) begin
            if (step_start) begin
                if (n_ss < 3) begin ss_age[n_ss] = age; ss_ts[n_ss] = int'(timestep); end
                n_ss++;
            end
            if (run_done && rd_age < 0) rd_age = age;
            start = (age == 15);
            tick();
        end
        start = 1'b0;
        cmp("norm_pulses", n_ss, 3);
        cmp("norm_ss0", ss_age[0], 0);
        cmp("norm_ss1", ss_age[1], 11);
        cmp("norm_ss2", ss_age[2], 22);
        cmp("norm_ts0", ss_ts[0], 0);
        cmp("norm_ts1", ss_ts[1], 1);
        cmp("norm_ts2", ss_ts[2], 2);
        cmp("norm_rd", rd_age, 33);
        quiet(); tick();

        // Staggered single-node done pulses
        cfg_num_steps = 1; start = 1'b1;
        tick();
        start = 1'b0; rd_age = -1;
        for (int age = 0; age < 30; age++) begin
            node_done = (age == 2) ? 4'b0001 : (age == 5) ? 4'b0010 :
                        (age == 9) ? 4'b0100 : (age == 14) ? 4'b1000 : 4'b0000;
            if (age == 1)  cmp("stag_pm1",  32'(pending_mask), 32'hF);
            if (age == 3)  cmp("stag_pm3",  32'(pending_mask), 32'hE);
            if (age == 6)  cmp("stag_pm6",  32'(pending_mask), 32'hC);
            if (age == 10) cmp("stag_pm10", 32'(pending_mask), 32'h8);
            if (age == 14) cmp("stag_pm14", 32'(pending_mask), 32'h8);
            if (age == 15) cmp("stag_pm15", 32'(pending_mask), 32'h0);
            if (run_done && rd_age < 0) rd_age = age;
            tick();
        end
        cmp("stag_rd", rd_age, 24);
        quiet(); tick();

        // Drain interrupted by a single busy NoC cycle
        cfg_num_steps = 1; node_done = '1; start = 1'b1;
        tick();
        start = 1'b0; rd_age = -1;
        for (int age = 0; age < 25; age++) begin
            noc_idle = (age != 7);
            if (run_done && rd_age < 0) rd_age = age;
            tick();
        end
        cmp("drain_rd", rd_age, 17);
        quiet(); tick();

        // Watchdog timeout with node 2 stuck
        cfg_num_steps = 2; cfg_timeout = 20; node_done = 4'b1011; start = 1'b1;
        tick();
        start = 1'b0;
        for (int age = 0; age < 25; age++) begin
            if (age == 20) cmp("to_early", 32'(timeout_err), 0);
            if (age == 21) begin
                cmp("to_err", 32'(timeout_err), 1);
                cmp("to_pm", 32'(pending_mask), 32'h4);
            end
            start = (age == 22 || age == 23);
            tick();
        end
        start = 1'b0;
        cmp("to_hold", 32'(timeout_err), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_all_zero("to_abort");
        quiet(); tick();

        // Zero-step run
        cfg_num_steps = 0; start = 1'b1;
        tick();
        start = 1'b0;
        cmp("zero_rd", 32'(run_done), 1);
        cmp("zero_ss", 32'(step_start), 0);
        tick();
        cmp("zero_rd_end", 32'(run_done), 0);
        cmp("zero_busy_end", 32'(busy), 0);

        // Abort during DRAIN of step 1
        cfg_num_steps = 3; node_done = '1; noc_idle = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int age = 0; age < 16; age++) begin
            if (age == 15) cmp("ab_ts_before", 32'(timestep), 1);
            abort = (age == 15);
            tick();
        end
        abort = 1'b0;
        cmp("ab_busy", 32'(busy), 0);
        cmp("ab_ts", 32'(timestep), 0);
        cmp("ab_rd", 32'(run_done), 0);
        quiet(); tick();

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst           = ($urandom_range(0, 399) != 0);
            start         = ($urandom_range(0, 9) == 0);
            abort         = ($urandom_range(0, 149) == 0);
            cfg_num_steps = TSW'($urandom_range(1, 4));
            cfg_timeout   = ($urandom_range(0, 3) == 0) ? '0 : TOW'($urandom_range(3, 30));
            node_done     = NN'($urandom & $urandom);
            noc_idle      = ($urandom_range(0, 7) != 0);
            tick();
        end

        quiet(); tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
